load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, giving the number of word-address bits forwarded to data memory; mem_addr bits above ADDR_W are zero.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU access request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  zero-extend the load when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  access was misaligned or illegal; qualified by resp_valid.
- mem_rd  out  1  data-memory read enable.
- mem_wr  out  1  data-memory write enable.
- mem_addr  out  32  word address, equal to captured req_addr[ADDR_W+1:2].
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory output, valid the cycle after mem_rd is sampled.

Function
REQ-003 SHALL implement FSM states IDLE, RD, CAP, WR, DONE; req_ready SHALL be 1 only in IDLE.
REQ-004 SHALL capture req_* on the edge where req_valid and req_ready are both 1, and hold the captured values until DONE.
REQ-005 SHALL route an accepted request as follows:
- misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size 11 -> DONE with no memory access.
- load -> RD.
- word store -> WR.
- byte/half store -> RD.
REQ-006 SHALL drive mem_rd=1 only in RD and mem_wr=1 only in WR, both decoded from registered state, never both at once.
REQ-007 SHALL always advance RD -> CAP.
REQ-008 In CAP, SHALL:
- for a load: register the extracted and extended lane into resp_rdata, then go to DONE.
- for a store: register mem_rdata, merged with the store lane, into the write-data register, then go to WR.
REQ-009 SHALL always advance WR -> DONE, with mem_wdata stable for the whole WR cycle because memory writes on the falling edge.
REQ-010 In DONE, SHALL assert resp_valid for exactly one cycle, assert resp_err per REQ-005, and then return to IDLE.
REQ-011 SHALL use big-endian byte lanes:
- byte offset 0 = bits 31:24, offset 3 = bits 7:0.
- half offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-012 SHALL sign- or zero-extend load data to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-013 SHALL leave non-target bytes of a sub-word store equal to the word read in RD/CAP.
REQ-014 SHALL hold resp_rdata = 0 for stores and error responses.
REQ-015 Latency, counted from the accept edge to the resp_valid cycle:
- error: 1 cycle.
- word store: 2 cycles.
- load: 3 cycles.
- sub-word store: 4 cycles.
REQ-016 SHALL have no pipelining: at most one request is outstanding, and the next accept can occur no earlier than the cycle after DONE.

Reset
REQ-017 SHALL, while rst_n=0, force:
- state = IDLE and req_ready = 1.
- resp_valid = 0, resp_err = 0, resp_rdata = 0.
- mem_rd = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
REQ-018 If reset asserts mid-operation, including during WR before the falling edge, SHALL suppress the pending write and SHALL NOT emit a response; operation resumes in IDLE on the first edge after release.

Structure
REQ-019 SHALL place the state encoding, the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and ADDR_W's default in shared package mips_mem_pkg.
REQ-020 SHALL implement lane extract/extend and lane merge in one combinational sub-module, lsu_lane, instantiated once.

Verification
REQ-021 Bench SHALL use a behavioural word memory matching the data-memory timing: read on the rising edge, write on the falling edge.
REQ-022 SHALL cover these directed scenarios:
- word 0x10 = 0x8899AABB; lb at 0x11 signed -> resp_rdata 0xFFFFFF99, resp_valid 3 cycles after accept.
- same word; lhu at 0x12 -> resp_rdata 0x0000AABB.
- word 0x20 = 0x11223344; sb 0x000000EE at 0x23 -> word reads 0x112233EE; exactly one mem_rd cycle and one mem_wr cycle; resp_valid 4 cycles after accept.
- sw 0xDEADBEEF at 0x40 -> mem_rd never 1; mem_addr 0x10 in WR; resp 2 cycles after accept.
- lw at 0x42 -> resp_err=1, resp_rdata=0, no mem_rd/mem_wr, resp 1 cycle after accept.
- rst_n low during WR of sw 0x55555555 at 0x40 -> memory word unchanged, no resp_valid, req_ready=1 immediately.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// access-size codes and the default word-address width.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ADDR_W_DEF = 16;

    // Illegal size code or an offset that does not fit the access size.
    function automatic logic lsu_bad(
        input logic [1:0] size,
        input logic [1:0] off
    );
        unique case (size)
            SZ_BYTE: lsu_bad = 1'b0;
            SZ_HALF: lsu_bad = off[0];
            SZ_WORD: lsu_bad = |off;
            default: lsu_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane logic: extracts/extends a load lane and merges a
// store lane into a read word.
// Ports: i_size, i_off, i_uns, i_rdata, i_wdata -> o_ldata, o_merged.
module lsu_lane
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_uns,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_ldata,
    output logic [31:0] o_merged
);

    // Offset 0 is the most significant lane.
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bsh  = {~i_off, 3'b000};
    assign w_hsh  = {~i_off[1], 4'b0000};
    assign w_byte = 8'(i_rdata >> w_bsh);
    assign w_half = 16'(i_rdata >> w_hsh);

    always_comb begin
        o_ldata  = i_rdata;
        o_merged = i_rdata;
        unique case (i_size)
            SZ_BYTE: begin
                o_ldata  = {{24{~i_uns & w_byte[7]}}, w_byte};
                o_merged = (i_rdata & ~(32'hFF << w_bsh))
                         | (32'(i_wdata[7:0]) << w_bsh);
            end
            SZ_HALF: begin
                o_ldata  = {{16{~i_uns & w_half[15]}}, w_half};
                o_merged = (i_rdata & ~(32'hFFFF << w_hsh))
                         | (32'(i_wdata) << w_hsh);
            end
            default: begin
                o_ldata  = i_rdata;
                o_merged = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Non-pipelined load/store unit: one request at a time, sub-word
// stores done as read-modify-write. Ports: req_* (CPU side),
// resp_* (completion), mem_* (synchronous data memory).
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_bad;
    logic [31:0] w_ldata;
    logic [31:0] w_merged;
    logic        w_unused;

    assign w_bad    = lsu_bad(req_size, req_addr[1:0]);
    // Address bits above the memory window are dropped on purpose.
    assign w_unused = ^req_addr;

    assign req_ready  = (r_state == IDLE);
    assign mem_rd     = (r_state == RD);
    assign mem_wr     = (r_state == WR);
    assign resp_valid = (r_state == DONE);
    assign resp_err   = r_err & (r_state == DONE);
    assign resp_rdata = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    lsu_lane u_lane (
        .i_size   (r_size),
        .i_off    (r_off),
        .i_uns    (r_uns),
        .i_rdata  (mem_rdata),
        .i_wdata  (r_wdata),
        .o_ldata  (w_ldata),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_uns      <= req_unsigned;
                        r_off      <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        r_err      <= w_bad;
                        r_rdata    <= '0;
                        r_mem_addr <= {{(32-ADDR_W){1'b0}},
                                       req_addr[ADDR_W+1:2]};
                        if (w_bad) begin
                            r_state <= DONE;
                        end else if (!req_we) begin
                            r_state <= RD;
                        end else if (req_size == SZ_WORD) begin
                            r_mem_wdata <= req_wdata;
                            r_state     <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    if (!r_we) begin
                        r_rdata <= w_ldata;
                        r_state <= DONE;
                    end else begin
                        r_mem_wdata <= w_merged;
                        r_state     <= WR;
                    end
                end
                WR:   r_state <= DONE;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a behavioural word
// memory (read on rising edge, write on falling edge).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always @(posedge clk)
        if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];

    always @(negedge clk)
        if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request and watch it until resp_valid (bounded).
    task automatic run(
        input  logic        we,
        input  logic [1:0]  sz,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          lat,
        output int          n_rd,
        output int          n_wr,
        output logic [31:0] rdata,
        output logic        err,
        output logic [31:0] wr_addr,
        output logic [31:0] hi_addr
    );
        lat = 0; n_rd = 0; n_wr = 0;
        rdata = 'x; err = 1'bx;
        wr_addr = 'x; hi_addr = '0;
        @(negedge clk);
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we;
        req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mem_rd) n_rd++;
            if (mem_wr) begin
                n_wr++;
                wr_addr = mem_addr;
            end
            if (mem_rd && mem_wr) n_rd += 100;
            hi_addr |= {mem_addr[31:16], 16'h0};
            if (resp_valid) begin
                lat = i; rdata = resp_rdata;
                err = resp_err;
                break;
            end
        end
        @(negedge clk);
        chk("one_pulse", 32'(resp_valid), 32'd0);
    endtask

    int          lat, nr, nw;
    logic [31:0] rd, wa, ha;
    logic        er;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h11223344;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // lb 0x11 signed
        run(0, 2'b00, 0, 32'h11, 0, lat, nr, nw, rd, er, wa, ha);
        chk("lb_data", rd, 32'hFFFFFF99);
        chk("lb_lat", lat, 3);
        chk("lb_err", 32'(er), 0);
        chk("lb_nrd", nr, 1);
        chk("lb_nwr", nw, 0);

        // lhu 0x12
        run(0, 2'b01, 1, 32'h12, 0, lat, nr, nw, rd, er, wa, ha);
        chk("lhu_data", rd, 32'h0000AABB);
        chk("lhu_lat", lat, 3);

        // lh 0x10 signed, lbu 0x13
        run(0, 2'b01, 0, 32'h10, 0, lat, nr, nw, rd, er, wa, ha);
        chk("lh_data", rd, 32'hFFFF8899);
        run(0, 2'b00, 1, 32'h13, 0, lat, nr, nw, rd, er, wa, ha);
        chk("lbu_data", rd, 32'h000000BB);

        // lw 0x10, unsigned flag ignored
        run(0, 2'b10, 1, 32'h10, 0, lat, nr, nw, rd, er, wa, ha);
        chk("lw_data", rd, 32'h8899AABB);

        // sb 0xEE at 0x23
        run(1, 2'b00, 0, 32'h23, 32'hEE,
            lat, nr, nw, rd, er, wa, ha);
        chk("sb_mem", mem[8], 32'h112233EE);
        chk("sb_lat", lat, 4);
        chk("sb_nrd", nr, 1);
        chk("sb_nwr", nw, 1);
        chk("sb_rdata", rd, 0);

        // sh 0xCAFE at 0x20
        run(1, 2'b01, 0, 32'h20, 32'h1234CAFE,
            lat, nr, nw, rd, er, wa, ha);
        chk("sh_mem", mem[8], 32'hCAFE33EE);
        chk("sh_lat", lat, 4);

        // sw 0xDEADBEEF at 0x40
        run(1, 2'b10, 0, 32'h40, 32'hDEADBEEF,
            lat, nr, nw, rd, er, wa, ha);
        chk("sw_mem", mem[16], 32'hDEADBEEF);
        chk("sw_nrd", nr, 0);
        chk("sw_nwr", nw, 1);
        chk("sw_waddr", wa, 32'h10);
        chk("sw_lat", lat, 2);
        chk("sw_rdata", rd, 0);

        // misaligned lw at 0x42
        run(0, 2'b10, 0, 32'h42, 0, lat, nr, nw, rd, er, wa, ha);
        chk("mis_err", 32'(er), 1);
        chk("mis_rdata", rd, 0);
        chk("mis_nrd", nr, 0);
        chk("mis_nwr", nw, 0);
        chk("mis_lat", lat, 1);

        // misaligned half, illegal size
        run(0, 2'b01, 0, 32'h11, 0, lat, nr, nw, rd, er, wa, ha);
        chk("mish_err", 32'(er), 1);
        run(1, 2'b11, 0, 32'h20, 32'hFF,
            lat, nr, nw, rd, er, wa, ha);
        chk("sz11_err", 32'(er), 1);
        chk("sz11_nwr", nw, 0);
        chk("sz11_mem", mem[8], 32'hCAFE33EE);

        // high address bits above ADDR_W dropped
        run(0, 2'b10, 0, 32'hFFFC0010, 0,
            lat, nr, nw, rd, er, wa, ha);
        chk("hi_addr", ha, 0);
        chk("hi_data", rd, 32'h8899AABB);

        // reset during WR of sw 0x55555555 at 0x40
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1;
        req_size = 2'b10; req_addr = 32'h40;
        req_wdata = 32'h55555555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("pre_rst_wr", 32'(mem_wr), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mid_rst_wr", 32'(mem_wr), 0);
        chk("mid_rst_rv", 32'(resp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nr = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) nr++;
        end
        chk("rst_no_resp", nr, 0);
        chk("rst_mem", mem[16], 32'hDEADBEEF);

        // resumes normally after reset
        run(0, 2'b00, 0, 32'h11, 0, lat, nr, nw, rd, er, wa, ha);
        chk("post_lb", rd, 32'hFFFFFF99);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
